// File: rtl/delay_pkg.sv
// Shared definitions for the delay subsystem: FSM state encoding, counter width
// helper and default timing constants.
package delay_pkg;

    localparam int REFCLK_F_DEF = 100;
    localparam int POR_US_DEF   = 1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIRE = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/delay_if.sv
// Trigger/pulse bundle between the delay core and its user.
// cancel_i exists only when DELAY_CANCEL_EN is defined.
interface delay_if #(
    parameter int DLY_W = 16
);

    logic             trig_i;
    logic [DLY_W-1:0] dly_us_i;
    logic             pulse_o;
    logic             busy_o;
    logic             ready_o;
    logic             us_tick_o;
`ifdef DELAY_CANCEL_EN
    logic             cancel_i;
`endif

`ifdef DELAY_CANCEL_EN
    modport master (output trig_i, dly_us_i, cancel_i,
                    input  pulse_o, busy_o, ready_o, us_tick_o);
    modport slave  (input  trig_i, dly_us_i, cancel_i,
                    output pulse_o, busy_o, ready_o, us_tick_o);
`else
    modport master (output trig_i, dly_us_i,
                    input  pulse_o, busy_o, ready_o, us_tick_o);
    modport slave  (input  trig_i, dly_us_i,
                    output pulse_o, busy_o, ready_o, us_tick_o);
`endif

endinterface

// File: rtl/delay_us_tick.sv
// Modulo-PERIOD counter advancing on en; wrap flags the enabled cycle in which
// the counter sits at PERIOD-1. Used as the 1 us prescaler and the power-up counter.
module delay_us_tick
    import delay_pkg::*;
#(
    parameter int PERIOD = REFCLK_F_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic wrap
);

    localparam int            CW   = cnt_w(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign wrap = en && (cnt == LAST);

endmodule

// File: rtl/delay_top_core.sv
// Reference-clock delay block: 1 us tick, power-up ready delay and a
// programmable trigger-to-pulse delay. Optional cancel input: DELAY_CANCEL_EN.
module delay_top_core
    import delay_pkg::*;
#(
    parameter int REFCLK_F = REFCLK_F_DEF,
    parameter int DLY_W    = 16,
    parameter int POR_US   = POR_US_DEF
) (
    input logic     ref_clk,
    input logic     resetn,
    delay_if.slave  bus
);

    localparam int CW = cnt_w(REFCLK_F);
    localparam int TW = DLY_W + CW;

    logic          run;
    logic          pre_wrap;
    logic          por_wrap;
    logic          us_tick;
    logic          ready;
    logic          pulse;
    logic          busy;
    state_t        state;
    logic [TW-1:0] cyc;
    logic [TW-1:0] last_cyc;

    // run holds the prescaler still on the first edge out of reset so the
    // first tick lands exactly REFCLK_F edges later.
    delay_us_tick #(.PERIOD(REFCLK_F)) u_prescale (
        .clk    (ref_clk),
        .resetn (resetn),
        .en     (run),
        .wrap   (pre_wrap)
    );

    delay_us_tick #(.PERIOD(POR_US)) u_por (
        .clk    (ref_clk),
        .resetn (resetn),
        .en     (us_tick),
        .wrap   (por_wrap)
    );

    always_ff @(posedge ref_clk) begin
        if (!resetn) begin
            run      <= 1'b0;
            us_tick  <= 1'b0;
            ready    <= 1'b0;
            pulse    <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
            cyc      <= '0;
            last_cyc <= '0;
        end else begin
            run     <= 1'b1;
            us_tick <= pre_wrap;
            ready   <= ready | por_wrap;
            pulse   <= (state == ST_FIRE);
            busy    <= (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (ready && bus.trig_i) begin
                        cyc      <= '0;
                        last_cyc <= TW'(bus.dly_us_i) * TW'(REFCLK_F) - TW'(1);
                        state    <= (bus.dly_us_i == '0) ? ST_FIRE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
`ifdef DELAY_CANCEL_EN
                    if (bus.cancel_i) begin
                        state <= ST_IDLE;
                    end else
`endif
                    if (cyc == last_cyc) begin
                        state <= ST_FIRE;
                    end else begin
                        cyc <= cyc + TW'(1);
                    end
                end
                ST_FIRE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.us_tick_o = us_tick;
    assign bus.ready_o   = ready;
    assign bus.pulse_o   = pulse;
    assign bus.busy_o    = busy;

endmodule

// File: tb/tb_delay_top_core.sv
// Directed bench for delay_top_core at REFCLK_F=100, POR_US=10.
module tb_delay_top_core;

    logic ref_clk = 1'b0;
    logic resetn  = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 ref_clk = ~ref_clk;

    delay_if #(.DLY_W(16)) bus ();

    delay_top_core #(.REFCLK_F(100), .DLY_W(16), .POR_US(10)) dut (
        .ref_clk (ref_clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    // Called just after resetn rises; leaves the bench just after edge 1001.
    task automatic por_run(input bit poke);
        int tick_err;
        int busy_seen;
        int pulse_seen;
        int ready_err;
        tick_err = 0; busy_seen = 0; pulse_seen = 0; ready_err = 0;
        for (int e = 0; e <= 1000; e++) begin
            adv(1);
            if (bus.us_tick_o !== ((e > 0 && e % 100 == 0) ? 1'b1 : 1'b0)) tick_err++;
            if (bus.busy_o !== 1'b0) busy_seen++;
            if (bus.pulse_o !== 1'b0) pulse_seen++;
            if (bus.ready_o !== 1'b0) ready_err++;
            bus.trig_i = poke && (e == 200 || e == 500);
        end
        bus.trig_i = 1'b0;
        chk("tick_pattern", tick_err, 0);
        chk("busy_before_ready", busy_seen, 0);
        chk("pulse_before_ready", pulse_seen, 0);
        chk("ready_early", ready_err, 0);
        adv(1);
        chk("ready_at_1001", bus.ready_o, 1);
    endtask

    initial begin
        int np;
        int pe [3];

        bus.trig_i   = 1'b0;
        bus.dly_us_i = '0;
`ifdef DELAY_CANCEL_EN
        bus.cancel_i = 1'b0;
`endif
        resetn = 1'b0;
        adv(3);
        chk("rst_pulse", bus.pulse_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_ready", bus.ready_o, 0);
        chk("rst_tick", bus.us_tick_o, 0);

        resetn = 1'b1;
        por_run(1'b1);

        // D=3, dly_us_i disturbed during WAIT
        bus.trig_i = 1'b1; bus.dly_us_i = 16'd3;
        adv(1);
        bus.trig_i = 1'b0;
        chk("d3_busy_e0", bus.busy_o, 0);
        adv(1);
        chk("d3_busy_e1", bus.busy_o, 1);
        bus.dly_us_i = 16'd9;
        adv(299);
        chk("d3_pulse_e300", bus.pulse_o, 0);
        chk("d3_busy_e300", bus.busy_o, 1);
        adv(1);
        chk("d3_pulse_e301", bus.pulse_o, 1);
        chk("d3_busy_e301", bus.busy_o, 1);
        adv(1);
        chk("d3_pulse_e302", bus.pulse_o, 0);
        chk("d3_busy_e302", bus.busy_o, 0);

        // D=0
        bus.trig_i = 1'b1; bus.dly_us_i = 16'd0;
        adv(1);
        bus.trig_i = 1'b0;
        chk("d0_pulse_e0", bus.pulse_o, 0);
        adv(1);
        chk("d0_pulse_e1", bus.pulse_o, 1);
        chk("d0_busy_e1", bus.busy_o, 1);
        adv(1);
        chk("d0_pulse_e2", bus.pulse_o, 0);
        chk("d0_busy_e2", bus.busy_o, 0);

        // D=5 with an ignored second trigger at E0+100
        bus.trig_i = 1'b1; bus.dly_us_i = 16'd5;
        adv(1);
        bus.trig_i = 1'b0; bus.dly_us_i = 16'd1;
        np = 0; pe[0] = -1;
        for (int e = 1; e <= 700; e++) begin
            adv(1);
            if (bus.pulse_o === 1'b1) begin
                np++;
                pe[0] = e;
            end
            bus.trig_i = (e == 99);
        end
        bus.trig_i = 1'b0;
        chk("d5_pulse_count", np, 1);
        chk("d5_pulse_edge", pe[0], 501);

        // trig held high, D=1: one pulse every 102 cycles
        bus.trig_i = 1'b1; bus.dly_us_i = 16'd1;
        np = 0; pe[0] = 0; pe[1] = 0; pe[2] = 0;
        for (int e = 1; e <= 400; e++) begin
            adv(1);
            if (bus.pulse_o === 1'b1 && np < 3) begin
                pe[np] = e;
                np++;
            end
        end
        chk("held_first", pe[0], 102);
        chk("held_period1", pe[1] - pe[0], 102);
        chk("held_period2", pe[2] - pe[1], 102);
        chk("held_midwait_busy", bus.busy_o, 1);

        // reset in the middle of WAIT
        bus.trig_i = 1'b0;
        resetn = 1'b0;
        adv(1);
        chk("midrst_pulse", bus.pulse_o, 0);
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_ready", bus.ready_o, 0);
        chk("midrst_tick", bus.us_tick_o, 0);
        resetn = 1'b1;
        por_run(1'b0);

`ifdef DELAY_CANCEL_EN
        // cancel during WAIT
        bus.trig_i = 1'b1; bus.dly_us_i = 16'd4;
        adv(1);
        bus.trig_i = 1'b0;
        adv(49);
        bus.cancel_i = 1'b1;
        adv(1);
        bus.cancel_i = 1'b0;
        chk("cancel_busy_e50", bus.busy_o, 1);
        adv(1);
        chk("cancel_busy_e51", bus.busy_o, 0);
        np = 0;
        for (int e = 0; e < 500; e++) begin
            adv(1);
            if (bus.pulse_o !== 1'b0) np++;
        end
        chk("cancel_no_pulse", np, 0);

        // cancel held through IDLE and FIRE has no effect
        bus.trig_i = 1'b1; bus.dly_us_i = 16'd0; bus.cancel_i = 1'b1;
        adv(1);
        bus.trig_i = 1'b0;
        adv(1);
        chk("cancel_fire_pulse", bus.pulse_o, 1);
        bus.cancel_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_top_core.md
Name: delay_top_core

Overview:
- Reference-clock timing block.
- Derives a 1 us tick from ref_clk, holds a ready flag low for a fixed power-up delay after reset, then accepts trigger pulses and re-emits each one after a programmable delay given in microseconds.
- Sits at the top of the delay subsystem, directly on the board reference clock.

Parameters:
- REFCLK_F, 100, ref_clk frequency in MHz; integer >= 1; cycles per microsecond.
- DLY_W, 16, width of the programmable delay value in microseconds.
- POR_US, 1000, power-up delay in microseconds before ready_o asserts; >= 1.

Ports:
- ref_clk  input  1  reference clock; all logic on its rising edge.
- resetn  input  1  reset.
- trig_i  input  1  trigger request, sampled each cycle.
- dly_us_i  input  DLY_W  delay in us, sampled on trigger accept.
- pulse_o  output  1  delayed one-cycle output pulse.
- busy_o  output  1  delay in progress.
- ready_o  output  1  power-up delay elapsed.
- us_tick_o  output  1  one-cycle strobe every REFCLK_F cycles.

Interface: one clock; reset is synchronous and active-low (ref_clk, resetn).

Behaviour:
- All outputs registered. While resetn=0 at a clock edge: pulse_o=0, busy_o=0, ready_o=0, us_tick_o=0, all counters 0, FSM in IDLE.
- Prescaler:
  - Counter runs 0..REFCLK_F-1 and wraps.
  - us_tick_o is high for exactly the one cycle after the counter registers REFCLK_F-1.
  - First tick is high on clock edge REFCLK_F after the first edge that samples resetn=1.
  - Period is REFCLK_F cycles. For REFCLK_F=1, us_tick_o is constantly 1 after reset.
- Power-up:
  - Counts us_tick_o strobes.
  - ready_o goes high on the edge after the POR_US-th tick and stays high until reset.
- Delay FSM states: IDLE, WAIT, FIRE.
  - IDLE: if ready_o=1 and trig_i=1 at edge E0, latch dly_us_i as D and clear a private cycle counter. Go to FIRE if D=0, otherwise to WAIT.
  - WAIT: private counter counts REFCLK_F cycles per microsecond, independent of the global prescaler phase. After exactly D*REFCLK_F cycles spent in WAIT, go to FIRE.
  - FIRE: pulse_o=1 for one cycle, then return to IDLE.
  - Net latency: pulse_o is high in the cycle starting at edge E0 + D*REFCLK_F + 1.
  - busy_o=1 whenever state != IDLE, i.e. from edge E0+1 through the FIRE cycle inclusive.
- Boundary conditions:
  - trig_i while busy_o=1 or ready_o=0: ignored, not queued.
  - trig_i held high: re-accepted in the first IDLE cycle after FIRE, giving a pulse period of D*REFCLK_F+2 cycles.
  - dly_us_i changes during WAIT: no effect.
  - D = 2^DLY_W-1: no overflow. The private counters must be sized to hold DLY_W bits of microseconds plus clog2(REFCLK_F) bits.
  - Reset mid-WAIT or mid-FIRE: the pulse is aborted and ready_o re-runs the full power-up delay.

Optional Feature:
- Macro DELAY_CANCEL_EN.
- When defined: adds input cancel_i (1 bit). cancel_i=1 in WAIT returns the FSM to IDLE on the next edge with no pulse; busy_o drops that edge. cancel_i is ignored in IDLE and FIRE. If cancel_i and the final WAIT cycle coincide, cancel wins.
- When undefined: port absent; every accepted trigger produces exactly one pulse.

Decomposition:
- Package delay_pkg: FSM state enum (IDLE/WAIT/FIRE), the helper for clog2 widths, and the default constants REFCLK_F_DEF=100 and POR_US_DEF=1000.
- One sub-module, delay_us_tick: the prescaler producing us_tick_o. It is reused for the power-up counter.
- FSM and delay counters stay in delay_top_core.

Test Plan (REFCLK_F=100, POR_US=10):
- Reset release -> us_tick_o high exactly on edges 100, 200, 300…; ready_o rises on the edge after the 10th tick (edge 1001).
- trig_i pulse before ready_o -> no pulse_o and busy_o stays 0 through 2000 cycles.
- After ready, trig_i 1 cycle with dly_us_i=3 -> busy_o high at E0+1; pulse_o high exactly at E0+301 for 1 cycle; busy_o low at E0+302.
- dly_us_i=0 -> pulse_o at E0+1; second trig_i during busy (dly 5, trig again at E0+100) -> only one pulse, at E0+501.
- trig_i held high, dly_us_i=1 -> pulses every 102 cycles; resetn low mid-WAIT -> no pulse, all outputs 0, ready_o re-delays 1000 cycles.
- DELAY_CANCEL_EN: dly 4, cancel_i at E0+50 -> no pulse, busy_o low at E0+51.
